// File: rtl/mem_stage_sram_pkg.sv
// Shared types and constants for the memory stage that fronts a 16-bit external SRAM.
package mem_stage_sram_pkg;

    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mem_stage_sram_register.sv
// Generic holding register with synchronous active-high clear and load enable.
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear on reset, otherwise load when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= {WIDTH{1'b0}};
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage_sram.sv
// Memory stage: splits a 32-bit load/store into two 16-bit SRAM accesses and
// stalls the pipeline through ready while the access is in flight.
module mem_stage_sram
    import mem_stage_sram_pkg::*;
#(
    parameter int ADDR_BASE = 1024,
    parameter int SRAM_AW   = 18,
    parameter int WAIT      = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_R_EN,
    input  logic                   MEM_W_EN,
    input  logic [31:0]            ALU_result,
    input  logic [31:0]            Val_Rm,
    output logic                   ready,
    output logic [31:0]            mem_result,
    output logic [SRAM_AW-1:0]     sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    localparam int          IDX_W  = SRAM_AW - 1;
    localparam logic [2:0]  WAIT_C = 3'(WAIT);
    localparam logic [31:0] BASE_C = 32'(ADDR_BASE);

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [2:0]             wait_cnt_r;
    logic [2:0]             wait_cnt_nxt_s;
    logic                   is_store_r;
    logic                   op_store_nxt_s;
    logic                   req_s;
    logic                   last_s;
    logic                   start_s;
    logic                   low_done_s;
    logic                   high_done_s;
    logic                   active_nxt_s;
    logic [IDX_W-1:0]       idx_s;
    logic [SRAM_DATA_W-1:0] wdata_hi_r;
    logic                   addr_en_s;
    logic [SRAM_AW-1:0]     addr_d_s;
    logic                   dq_en_s;
    logic [SRAM_DATA_W-1:0] dq_d_s;
    logic                   res_en_s;
    logic [31:0]            res_d_s;

    assign req_s  = MEM_R_EN | MEM_W_EN;
    // Addresses outside the SRAM wrap; byte offset bits are dropped by the shift.
    assign idx_s  = IDX_W'((ALU_result - BASE_C) >> 2);
    assign last_s = (wait_cnt_r == WAIT_C);
    assign ready  = ((state_r == IDLE) & ~req_s) | (state_r == DONE);

    // Next-state and wait-counter logic for the two-half access sequence.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = 3'd0;
        start_s        = 1'b0;
        low_done_s     = 1'b0;
        high_done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_nxt_s = LOW;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOW: begin
                if (last_s) begin
                    state_nxt_s = HIGH;
                    low_done_s  = 1'b1;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 3'd1;
                end
            end
            HIGH: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                    high_done_s = 1'b1;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 3'd1;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // A store wins over a load when both are requested together.
    assign op_store_nxt_s = start_s ? MEM_W_EN : is_store_r;
    assign active_nxt_s   = (state_nxt_s == LOW) | (state_nxt_s == HIGH);

    // FSM state, wait counter and latched operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= 3'd0;
            is_store_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            is_store_r <= op_store_nxt_s;
        end
    end

    // Strobes are precomputed from the next state so the pins come straight off flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
        end else begin
            sram_we_n  <= ~(active_nxt_s & op_store_nxt_s);
            sram_oe_n  <= ~(active_nxt_s & ~op_store_nxt_s);
            sram_dq_oe <= active_nxt_s & op_store_nxt_s;
        end
    end

    // The high-half address is the low-half address with bit 0 set.
    assign addr_en_s = start_s | low_done_s;
    assign addr_d_s  = start_s ? {idx_s, 1'b0} : {sram_addr[SRAM_AW-1:1], 1'b1};
    assign dq_en_s   = (start_s & MEM_W_EN) | (low_done_s & is_store_r);
    assign dq_d_s    = start_s ? Val_Rm[15:0] : wdata_hi_r;
    assign res_en_s  = (low_done_s | high_done_s) & ~is_store_r;
    assign res_d_s   = low_done_s ? {mem_result[31:16], sram_dq_in}
                                  : {sram_dq_in, mem_result[15:0]};

    register #(.WIDTH(SRAM_AW)) u_addr_reg (
        .clk (clk),
        .rst (rst),
        .en  (addr_en_s),
        .d   (addr_d_s),
        .q   (sram_addr)
    );

    register #(.WIDTH(SRAM_DATA_W)) u_wdata_hi_reg (
        .clk (clk),
        .rst (rst),
        .en  (start_s & MEM_W_EN),
        .d   (Val_Rm[31:16]),
        .q   (wdata_hi_r)
    );

    register #(.WIDTH(SRAM_DATA_W)) u_dq_out_reg (
        .clk (clk),
        .rst (rst),
        .en  (dq_en_s),
        .d   (dq_d_s),
        .q   (sram_dq_out)
    );

    register #(.WIDTH(32)) u_result_reg (
        .clk (clk),
        .rst (rst),
        .en  (res_en_s),
        .d   (res_d_s),
        .q   (mem_result)
    );

endmodule

// File: tb/tb_mem_stage_sram.sv
// Self-checking bench for mem_stage_sram: three instances (WAIT=1, 0, 7) each backed
// by a behavioural 16-bit SRAM; loads are checked against a 32-bit word model.
module tb_mem_stage_sram;

    localparam int N = 3;

    logic        clk;
    logic        rst      [N];
    logic        r_en     [N];
    logic        w_en     [N];
    logic [31:0] alu      [N];
    logic [31:0] vrm      [N];
    logic        ready    [N];
    logic [31:0] res      [N];
    logic [17:0] saddr    [N];
    logic [15:0] dq_out   [N];
    logic [15:0] dq_in    [N];
    logic        dq_oe    [N];
    logic        we_n     [N];
    logic        oe_n     [N];
    logic        ovr;
    logic [11:0] cyc;

    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 12'd1;

    for (genvar g = 0; g < N; g++) begin : g_inst
        localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 7);
        logic [15:0] sram_mem [0:262143];

        mem_stage_sram #(.ADDR_BASE(1024), .SRAM_AW(18), .WAIT(W)) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .MEM_R_EN    (r_en[g]),
            .MEM_W_EN    (w_en[g]),
            .ALU_result  (alu[g]),
            .Val_Rm      (vrm[g]),
            .ready       (ready[g]),
            .mem_result  (res[g]),
            .sram_addr   (saddr[g]),
            .sram_dq_out (dq_out[g]),
            .sram_dq_oe  (dq_oe[g]),
            .sram_dq_in  (dq_in[g]),
            .sram_we_n   (we_n[g]),
            .sram_oe_n   (oe_n[g])
        );

        always @(posedge clk) begin
            if (!we_n[g] && dq_oe[g]) sram_mem[saddr[g]] <= dq_out[g];
        end

        assign dq_in[g] = ovr ? {4'hC, cyc} : sram_mem[saddr[g]];
    end

    function automatic int wait_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 7);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Observations of the most recent access.
    int          stall_o;
    int          n_we;
    int          n_oe;
    int          n_dqoe;
    logic [17:0] we_first, we_last, oe_first, oe_last;
    logic [15:0] wd_first, wd_last;
    logic [31:0] res_o;
    logic [15:0] dqh [0:63];
    logic [31:0] exp_last [N];

    task automatic access(input int i, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
        int k;
        n_we = 0; n_oe = 0; n_dqoe = 0; stall_o = 0;
        @(negedge clk);
        r_en[i] = r; w_en[i] = w; alu[i] = a; vrm[i] = d;
        #1;
        k = 0;
        while (ready[i] == 1'b0 && k < 40) begin
            stall_o++;
            dqh[k] = dq_in[i];
            if (!we_n[i]) begin
                if (n_we == 0) begin we_first = saddr[i]; wd_first = dq_out[i]; end
                we_last = saddr[i]; wd_last = dq_out[i]; n_we++;
            end
            if (!oe_n[i]) begin
                if (n_oe == 0) oe_first = saddr[i];
                oe_last = saddr[i]; n_oe++;
            end
            if (dq_oe[i]) n_dqoe++;
            @(negedge clk); #1;
            k++;
        end
        if (k >= 40) begin
            n_checks++; n_fail++;
            $display("FAIL access_timeout: got ready=0 for %0d cycles, required <=17", k);
        end
        res_o = res[i];
        chk("done_strobes", {29'd0, we_n[i], oe_n[i], dq_oe[i]}, 32'd6);
        r_en[i] = 1'b0; w_en[i] = 1'b0;
    endtask

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [17:0] exp_lo;
        logic [31:0] exp_res;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] model [int];
    int          wl [$];

    initial begin
        int          bad;
        int          w;
        int          key;
        logic        st;
        logic        rr;
        logic [16:0] idx;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] e;

        n_checks = 0; n_fail = 0;
        cyc = 12'd0; ovr = 1'b0;
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1; r_en[i] = 1'b0; w_en[i] = 1'b0;
            alu[i] = 32'd0; vrm[i] = 32'd0; exp_last[i] = 32'd0;
        end

        tbl[0] = '{1'b0, 1'b1, 32'd1032,   32'hDEADBEEF, 18'd4,       32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'd1032,   32'h0,        18'd4,       32'hDEADBEEF};
        tbl[2] = '{1'b0, 1'b1, 32'd525312, 32'h12345678, 18'd0,       32'h0};
        tbl[3] = '{1'b1, 1'b0, 32'd1024,   32'h0,        18'd0,       32'h12345678};
        tbl[4] = '{1'b0, 1'b1, 32'd1020,   32'hCAFEF00D, 18'h3FFFE,   32'h0};
        tbl[5] = '{1'b1, 1'b0, 32'd1023,   32'h0,        18'h3FFFE,   32'hCAFEF00D};
        tbl[6] = '{1'b0, 1'b1, 32'd1427,   32'hA5A55A5A, 18'd200,     32'h0};
        tbl[7] = '{1'b1, 1'b0, 32'd1424,   32'h0,        18'd200,     32'hA5A55A5A};

        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) rst[i] = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk("reset_ready", {31'd0, ready[i]}, 32'd1);
            chk("reset_result", res[i], 32'd0);
            chk("reset_addr_dq", {14'd0, saddr[i]} | {16'd0, dq_out[i]}, 32'd0);
            chk("reset_strobes", {29'd0, we_n[i], oe_n[i], dq_oe[i]}, 32'd6);
        end

        // Table: WAIT=1 stores/loads, address mapping and wrap.
        for (int t = 0; t < 8; t++) begin
            access(0, tbl[t].r, tbl[t].w, tbl[t].a, tbl[t].d);
            chk("tbl_stall", stall_o, 32'd5);
            if (tbl[t].w) begin
                chk("tbl_we_cycles", n_we, 32'd4);
                chk("tbl_dqoe_cycles", n_dqoe, 32'd4);
                chk("tbl_we_addr_lo", {14'd0, we_first}, {14'd0, tbl[t].exp_lo});
                chk("tbl_we_addr_hi", {14'd0, we_last}, {14'd0, tbl[t].exp_lo | 18'd1});
                chk("tbl_wdata_lo", {16'd0, wd_first}, {16'd0, tbl[t].d[15:0]});
                chk("tbl_wdata_hi", {16'd0, wd_last}, {16'd0, tbl[t].d[31:16]});
                chk("tbl_store_no_oe", n_oe, 32'd0);
                chk("tbl_store_keeps_result", res_o, exp_last[0]);
            end else begin
                chk("tbl_oe_cycles", n_oe, 32'd4);
                chk("tbl_load_no_dqoe", n_dqoe, 32'd0);
                chk("tbl_oe_addr_lo", {14'd0, oe_first}, {14'd0, tbl[t].exp_lo});
                chk("tbl_oe_addr_hi", {14'd0, oe_last}, {14'd0, tbl[t].exp_lo | 18'd1});
                chk("tbl_load_result", res_o, tbl[t].exp_res);
                exp_last[0] = tbl[t].exp_res;
            end
        end

        // Idle for 10 cycles.
        bad = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (ready[0] !== 1'b1 || we_n[0] !== 1'b1 || oe_n[0] !== 1'b1 ||
                dq_oe[0] !== 1'b0 || res[0] !== exp_last[0]) bad++;
        end
        chk("idle_bad_cycles", bad, 32'd0);

        // Dual request: the store is performed.
        access(0, 1'b1, 1'b1, 32'd1064, 32'h0BADF00D);
        chk("dual_stall", stall_o, 32'd5);
        chk("dual_no_oe", n_oe, 32'd0);
        chk("dual_we_cycles", n_we, 32'd4);
        chk("dual_result_kept", res_o, exp_last[0]);
        access(0, 1'b1, 1'b0, 32'd1064, 32'h0);
        chk("dual_readback", res_o, 32'h0BADF00D);
        exp_last[0] = 32'h0BADF00D;

        // Reset during the HIGH half of a load.
        @(negedge clk);
        r_en[0] = 1'b1; alu[0] = 32'd1032;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pre_high_oe", {31'd0, oe_n[0]}, 32'd0);
        chk("rst_pre_high_addr", {14'd0, saddr[0]}, 32'd5);
        rst[0] = 1'b1;
        @(negedge clk); #1;
        chk("rst_strobes", {29'd0, we_n[0], oe_n[0], dq_oe[0]}, 32'd6);
        chk("rst_result", res[0], 32'd0);
        rst[0] = 1'b0; r_en[0] = 1'b0; #1;
        chk("rst_ready", {31'd0, ready[0]}, 32'd1);
        @(negedge clk); #1;
        chk("rst_no_more_cycle", {29'd0, we_n[0], oe_n[0], ready[0]}, 32'd7);
        exp_last[0] = 32'd0;

        // WAIT sweep: dq_in changes every cycle to pin down the sample points.
        ovr = 1'b1;
        for (int i = 1; i < N; i++) begin
            w = wait_of(i);
            access(i, 1'b1, 1'b0, 32'd1040, 32'h0);
            chk("sweep_stall", stall_o, 2 * (1 + w) + 1);
            chk("sweep_oe_cycles", n_oe, 2 * (1 + w));
            e = {dqh[2 + 2 * w], dqh[1 + w]};
            chk("sweep_sample_points", res_o, e);
            exp_last[i] = e;
        end
        ovr = 1'b0;

        // Randomized stores/loads against a word-level model.
        for (int i = 0; i < N; i++) begin
            w = wait_of(i);
            model.delete();
            wl.delete();
            for (int n = 0; n < 30; n++) begin
                st = (wl.size() == 0) || ($urandom_range(0, 1) == 1);
                if (st) begin
                    idx = 17'($urandom);
                    d = $urandom;
                end else begin
                    idx = 17'(wl[$urandom_range(0, wl.size() - 1)]);
                    d = 32'd0;
                end
                a = 32'd1024 + {13'd0, idx, 2'b00} + 32'($urandom_range(0, 3))
                    + (32'($urandom_range(0, 3)) << 19);
                key = int'(idx);
                if (st) begin
                    rr = 1'($urandom_range(0, 1));
                    access(i, rr, 1'b1, a, d);
                    model[key] = d;
                    wl.push_back(key);
                    chk("rnd_store_stall", stall_o, 2 * (1 + w) + 1);
                    chk("rnd_store_addr", {14'd0, we_first}, {14'd0, idx, 1'b0});
                    chk("rnd_store_hi", {16'd0, wd_last}, {16'd0, d[31:16]});
                    chk("rnd_store_keeps_result", res_o, exp_last[i]);
                end else begin
                    access(i, 1'b1, 1'b0, a, d);
                    exp_last[i] = model[key];
                    chk("rnd_load_stall", stall_o, 2 * (1 + w) + 1);
                    chk("rnd_load_addr", {14'd0, oe_first}, {14'd0, idx, 1'b0});
                    chk("rnd_load_result", res_o, exp_last[i]);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_sram.md
# mem_stage_sram

Memory stage of the 5-stage pipeline. It turns a 32-bit load or store from the EXE/MEM register into two 16-bit accesses on the external SRAM. While an access is in flight it deasserts `ready`, which freezes the pipeline. Its `mem_result` feeds `MEM_Result_in` of the MEM/WB register; `ALU_result`, `Dest` and `WB_en` pass around it.

## Interface
- `ADDR_BASE`, 1024: byte address mapped to SRAM word 0.
- `SRAM_AW`, 18: SRAM address width, in 16-bit half-words.
- `WAIT`, 1: extra cycles per half access, legal range 0..7.

Ports:
- `clk`  in  1  clock. Single clock domain, rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `MEM_R_EN`  in  1  load request.
- `MEM_W_EN`  in  1  store request.
- `ALU_result`  in  32  byte address.
- `Val_Rm`  in  32  store data.
- `ready`  out  1  stage may advance; 0 means freeze the pipeline.
- `mem_result`  out  32  last completed load data.
- `sram_addr`  out  SRAM_AW  half-word address.
- `sram_dq_out`  out  16  write data.
- `sram_dq_oe`  out  1  drive enable for the DQ pad.
- `sram_dq_in`  in  16  read data.
- `sram_we_n`  out  1  write strobe, active low.
- `sram_oe_n`  out  1  output enable, active low.

## Operation
- **Word index:** `idx = (ALU_result - ADDR_BASE) >> 2`, truncated to SRAM_AW-1 bits. Out-of-range addresses wrap modulo the SRAM size; address bits [1:0] are ignored.
- **SRAM half-word addresses:** low half is `{idx,0}`, high half is `{idx,1}`.
- **FSM states:** IDLE, LOW, HIGH, DONE.
- **IDLE:**
  - With `MEM_W_EN` or `MEM_R_EN` high: latch `idx`, `Val_Rm` and the op, then go to LOW.
  - If both requests are high, the store wins.
  - With no request: stay in IDLE.
- **LOW:**
  - Held for 1+WAIT cycles using a 3-bit wait counter, then go to HIGH.
  - Read: on the last LOW cycle, sample `sram_dq_in` into `mem_result[15:0]`.
- **HIGH:**
  - Held for 1+WAIT cycles, then go to DONE.
  - Read: on the last HIGH cycle, sample into `mem_result[31:16]`.
- **DONE:** one cycle, then go to IDLE.
- **`ready`:** equals `(IDLE & ~MEM_R_EN & ~MEM_W_EN) | DONE`.
- **`mem_result`:** changes only at the two read sample points and holds between loads. A store never modifies it.
- **SRAM pins during LOW/HIGH:**
  - `sram_addr` shows the half's address.
  - Store: `sram_we_n=0`, `sram_dq_oe=1`, `sram_dq_out` = the latched half.
  - Load: `sram_oe_n=0`, `sram_dq_oe=0`.
- **SRAM pins in IDLE/DONE:** `sram_we_n=1`, `sram_oe_n=1`, `sram_dq_oe=0`; `sram_addr` and `sram_dq_out` hold their last values.
- **Reset values:**
  - State IDLE, wait counter 0.
  - `mem_result`=0, `sram_addr`=0, `sram_dq_out`=0.
  - `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0.
  - `ready` is then 1 iff there is no request.

## Timing
- Each SRAM strobe/DQ/address output depends on registered state only; there is no combinational path from any input to an SRAM pin.
- `ready` is combinational from state and the request inputs.
- **Access occupancy:** 1 IDLE cycle + 2·(1+WAIT) cycles + 1 DONE cycle. At WAIT=1 that is 6 cycles, with `ready`=1 only on the 6th.
- **Result availability:** load data is valid in `mem_result` during DONE. The MEM/WB register captures it at the end of DONE.
- **Input stability:** upstream holds the request inputs stable while `ready`=0. The block ignores input changes outside IDLE.
- **Back-to-back accesses:** a new request arriving in the cycle after DONE starts immediately; there are no idle bubbles inside the block.
- **Reset mid-access:** state returns to IDLE on the next edge with strobes deasserted; no further SRAM cycle is issued and the partial load data is discarded (`mem_result` is reset to 0).
- **WAIT=0:** LOW and HIGH last one cycle each, for a 4-cycle access.

## Structure
- **Shared pipeline package:**
  - FSM state typedef (2-bit encoding: IDLE=0, LOW=1, HIGH=2, DONE=3).
  - `SRAM_DATA_W`=16.
- **Sub-module:** none required. The wait counter and FSM fit in one module. The four 32/16/SRAM_AW-bit holding registers use the existing parameterised `register` cell with enable.

## Test plan
- **Store then load, WAIT=1:** store `Val_Rm`=32'hDEADBEEF at `ALU_result`=1024+8.
  - Write strobes go to `sram_addr` 4 then 5, with data BEEF then DEAD.
  - The following load from the same address gives `mem_result`=32'hDEADBEEF in its DONE cycle.
  - Each access shows `ready`=0 for 5 cycles, then 1.
- **Idle behaviour:** no request for 10 cycles. `ready` stays 1, all strobes stay high, `sram_dq_oe`=0, `mem_result` is unchanged.
- **Dual request:** `MEM_R_EN` and `MEM_W_EN` both high. A store is performed, no `sram_oe_n` pulse appears, and `mem_result` is unchanged.
- **Reset during HIGH of a load:** strobes are high on the next cycle, `mem_result`=0, state IDLE, and `ready`=1 once the requests drop.
- **WAIT sweep 0 and 7:** stall lengths are 3 and 17 cycles. The sample points are the last LOW and last HIGH cycles, verified by changing `sram_dq_in` every cycle.
- **Address wrap:** `ALU_result`=1024 + 2^19 maps to `sram_addr` 0/1, the same as `ALU_result`=1024.
